// File: rtl/adc_scan_sequencer.sv
// Round-robin scan controller for the LTC2308 conversion block.
// Captured samples are tagged with their channel and queued in a show-ahead FIFO.
module adc_scan_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_W         = 4,
  parameter int START_CYCLES   = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scan_enable,
  input  logic [7:0]        ch_mask,
  output logic              measure_start,
  output logic [2:0]        measure_ch,
  input  logic              measure_done,
  input  logic [11:0]       measure_dataread,
  input  logic              fifo_rd,
  output logic [15:0]       fifo_dout,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic              scan_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT, S_CAPTURE, S_GAP
  } state_t;

  // With no gap configured, a finished conversion goes straight back to channel selection.
  localparam state_t AFTER_CONV = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(FIFO_DEPTH);

  state_t             state, state_nxt;
  logic [7:0]         cnt;
  logic [2:0]         last_ch;
  logic               sel_ok;
  logic               timeout_evt;
  logic               wr_en, do_wr, do_rd, drop;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W:0]    level;

  function automatic logic [2:0] pick_ch(input logic [7:0] mask, input logic [2:0] last);
    logic [2:0] c;
    pick_ch = last;
    // Descending search so the nearest set bit after 'last' is the one kept.
    for (int i = 8; i >= 1; i--) begin
      c = last + 3'(i);
      if (mask[c]) pick_ch = c;
    end
  endfunction

  assign sel_ok = scan_enable && (ch_mask != 8'd0);

  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    case (state)
      S_IDLE:    if (sel_ok) state_nxt = S_SELECT;
      S_SELECT:  state_nxt = sel_ok ? S_START : S_IDLE;
      S_START:   if (cnt == 8'(START_CYCLES - 1)) state_nxt = S_WAIT;
      S_WAIT: begin
        // The first two WAIT cycles may still see the previous conversion's done level.
        if (cnt >= 8'd2 && measure_done) begin
          state_nxt = S_CAPTURE;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = AFTER_CONV;
          timeout_evt = 1'b1;
        end
      end
      S_CAPTURE: state_nxt = AFTER_CONV;
      S_GAP:     if (cnt == 8'(GAP_CYCLES - 1)) state_nxt = S_SELECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      last_ch    <= 3'd7;
      measure_ch <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
      if (state == S_SELECT && sel_ok) begin
        measure_ch <= pick_ch(ch_mask, last_ch);
        last_ch    <= pick_ch(ch_mask, last_ch);
      end
    end
  end

  assign measure_start = (state == S_START);
  assign scan_busy     = (state != S_IDLE);
  assign wr_en         = (state == S_CAPTURE);

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);
  assign fifo_level = level;
  assign fifo_dout  = mem[rd_ptr];

  // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
  assign do_rd = fifo_rd && !fifo_empty;
  assign do_wr = wr_en && (!fifo_full || do_rd);
  assign drop  = wr_en && fifo_full && !do_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 16'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= {1'b0, measure_ch, measure_dataread};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky flags: a new error event in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (timeout_evt)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer with a conversion-block model,
// a channel-order model and a queue-based FIFO reference.
module tb_adc_scan_sequencer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_enable = 1'b0;
  logic [7:0]  ch_mask = 8'd0;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done = 1'b0;
  logic [11:0] measure_dataread = 12'd0;
  logic        fifo_rd = 1'b0;
  logic [15:0] fifo_dout;
  logic        fifo_empty, fifo_full;
  logic [4:0]  fifo_level;
  logic        overflow, timeout_err;
  logic        err_clr = 1'b0;
  logic        scan_busy;

  adc_scan_sequencer dut (
    .clk(clk), .reset_n(reset_n), .scan_enable(scan_enable), .ch_mask(ch_mask),
    .measure_start(measure_start), .measure_ch(measure_ch), .measure_done(measure_done),
    .measure_dataread(measure_dataread), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr), .scan_busy(scan_busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] q[$];
  int          model_last = 7;
  bit          exp_ovf = 1'b0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  bit          adc_never = 1'b0;
  bit          data_fixed = 1'b1;
  bit          rd_in_capture = 1'b0;
  int          rd_ph = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int next_ch(input logic [7:0] m, input int last);
    for (int k = 1; k <= 8; k++)
      if (m[(last + k) % 8]) return (last + k) % 8;
    return last;
  endfunction

  task automatic model_capture(input logic [15:0] e);
    if (rd_in_capture) begin
      chk("rdcap_model_full", 32'(q.size()), 32'(DEPTH));
      if (q.size() > 0) chk("rdcap_head", 32'(fifo_dout), 32'(q.pop_front()));
      rd_in_capture = 1'b0;
      rd_ph = 2;
    end
    if (q.size() < DEPTH) q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  // Conversion-block model: clears done 3 cycles after the start edge, raises it after a random latency.
  initial begin
    int since = 100;
    int lat = 0;
    int width = 0;
    bit pend = 1'b0;
    logic prev_start = 1'b0;
    logic [2:0] ch = 3'd0;
    logic [11:0] d;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0; prev_start = 1'b0; width = 0; rd_ph = 0; since = 100;
        continue;
      end
      if (rd_ph == 2) begin fifo_rd = 1'b1; rd_ph = 1; end
      else if (rd_ph == 1) begin fifo_rd = 1'b0; rd_ph = 0; end
      if (measure_start && !prev_start) begin
        start_cnt++;
        chk("scan_ch", 32'(measure_ch), 32'(next_ch(ch_mask, model_last)));
        model_last = next_ch(ch_mask, model_last);
        ch = measure_ch; since = 0; width = 1;
        pend = !adc_never;
        lat = $urandom_range(5, 20);
      end else begin
        since++;
        if (measure_start) width++;
        else if (prev_start) chk("start_width", 32'(width), 32'd2);
      end
      prev_start = measure_start;
      if (since == 3) measure_done = 1'b0;
      if (pend && since == lat) begin
        d = data_fixed ? (12'h100 + 12'(ch)) : 12'($urandom);
        measure_dataread = d;
        measure_done = 1'b1;
        done_cnt++;
        pend = 1'b0;
        model_capture({1'b0, ch, d});
      end
    end
  end

  task automatic pop_check(input string tag);
    if (q.size() == 0) chk({tag, "_model_empty"}, 32'(fifo_dout), 32'hFFFF_FFFF);
    else chk(tag, 32'(fifo_dout), 32'(q.pop_front()));
    fifo_rd = 1'b1;
  endtask

  task automatic run_conv(input int n, input bit rd);
    int target;
    target = done_cnt + n;
    for (int c = 0; c < n * 60 && done_cnt < target; c++) begin
      @(negedge clk);
      if (rd) begin
        fifo_rd = 1'b0;
        if (!fifo_empty && $urandom_range(0, 1) == 1) pop_check("rd_data");
      end
    end
    if (rd) begin @(negedge clk); fifo_rd = 1'b0; end
    chk("conv_progress", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int c = 0; c < 1000 && scan_busy; c++) @(negedge clk);
    chk("idle_reached", 32'(scan_busy), 32'd0);
  endtask

  task automatic wait_start();
    int c = 0;
    do begin @(negedge clk); c++; end while (!measure_start && c < 200);
    chk("start_seen", 32'(measure_start), 32'd1);
  endtask

  task automatic drain();
    fifo_rd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      fifo_rd = 1'b0;
      if (fifo_empty) break;
      pop_check("drain_data");
    end
    @(negedge clk);
    fifo_rd = 1'b0;
    chk("drain_left", 32'(q.size()), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  task automatic stop_and_drain();
    scan_enable = 1'b0;
    wait_idle();
    drain();
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    int base;
    logic [2:0] c1;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(measure_start), 32'd0);
    chk("rst_ch", 32'(measure_ch), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_dout", 32'(fifo_dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;

    ch_mask = 8'd0; scan_enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("mask0_busy", 32'(scan_busy), 32'd0);

    ch_mask = 8'hFF; data_fixed = 1'b1;
    run_conv(20, 1'b1);
    stop_and_drain();

    ch_mask = 8'b1000_0100; data_fixed = 1'b0; scan_enable = 1'b1;
    run_conv(6, 1'b1);
    stop_and_drain();

    for (int r = 0; r < 3; r++) begin
      ch_mask = 8'($urandom_range(1, 255)); scan_enable = 1'b1;
      run_conv(5, 1'b1);
      stop_and_drain();
    end

    // Overflow: exactly 17 conversions with no reads.
    ch_mask = 8'hFF; data_fixed = 1'b1; exp_ovf = 1'b0;
    base = start_cnt; scan_enable = 1'b1;
    for (int c = 0; c < 2000 && start_cnt < base + 17; c++) @(negedge clk);
    scan_enable = 1'b0;
    wait_idle();
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'(exp_ovf));
    chk("ovf_head", 32'(fifo_dout), 32'(q[0]));
    pulse_err_clr();
    exp_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the capture cycle.
    rd_in_capture = 1'b1; base = done_cnt; scan_enable = 1'b1;
    for (int c = 0; c < 200 && done_cnt == base; c++) @(negedge clk);
    scan_enable = 1'b0;
    wait_idle();
    chk("rdcap_level", 32'(fifo_level), 32'd16);
    chk("rdcap_ovf", 32'(overflow), 32'd0);
    drain();
    fifo_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rd_empty_level", 32'(fifo_level), 32'd0);
    chk("rd_empty_flag", 32'(fifo_empty), 32'd1);
    fifo_rd = 1'b0;

    // Timeout.
    ch_mask = 8'b0000_0011; adc_never = 1'b1; scan_enable = 1'b1;
    wait_start();
    c1 = measure_ch;
    repeat (201) @(negedge clk);
    chk("tmo_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("tmo_set", 32'(timeout_err), 32'd1);
    chk("tmo_nowrite", 32'(fifo_level), 32'd0);
    wait_start();
    chk("tmo_next_ch", 32'(measure_ch), 32'(c1 ^ 3'd1));
    scan_enable = 1'b0;
    wait_idle();
    chk("tmo_level", 32'(fifo_level), 32'd0);
    pulse_err_clr();
    chk("tmo_clr", 32'(timeout_err), 32'd0);

    // Reset in the middle of WAIT with samples already queued.
    adc_never = 1'b0; ch_mask = 8'hFF; scan_enable = 1'b1;
    run_conv(2, 1'b0);
    adc_never = 1'b1;
    wait_start();
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_start", 32'(measure_start), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_busy", 32'(scan_busy), 32'd0);
    chk("mrst_empty", 32'(fifo_empty), 32'd1);
    chk("mrst_dout", 32'(fifo_dout), 32'd0);
    q.delete(); model_last = 7; exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    adc_never = 1'b0;
    reset_n = 1'b1;
    run_conv(3, 1'b1);
    stop_and_drain();
    chk("end_ovf", 32'(overflow), 32'(exp_ovf));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Multi-channel scan controller that sits directly upstream of the LTC2308 conversion block.
- Drives that block's measure_start and measure_ch, waits for measure_done, then captures measure_dataread.
- Pushes channel-tagged samples into an internal show-ahead FIFO, which the downstream DSP/readout logic drains.
- Runs continuous round-robin scanning over a channel mask.

Parameters:
- FIFO_DEPTH, 16: FIFO entries; must be a power of 2.
- ADDR_W, 4: log2(FIFO_DEPTH).
- START_CYCLES, 2: cycles measure_start is held high (range 1..15).
- GAP_CYCLES, 4: idle cycles between a capture and the next channel select (range 0..255).
- TIMEOUT_CYCLES, 200: maximum WAIT cycles before the conversion is abandoned (range 1..255; a conversion nominally takes about 80 cycles).

Ports:
- clk  in  1  system clock, max 40 MHz, same clock as the conversion block.
- reset_n  in  1  asynchronous active-low reset.
- scan_enable  in  1  level; high = keep scanning.
- ch_mask  in  8  bit i high = channel i is in the scan list.
- measure_start  out  1  conversion trigger; the conversion block starts on the rising edge.
- measure_ch  out  3  channel for the current conversion.
- measure_done  in  1  conversion-complete level from the conversion block.
- measure_dataread  in  12  conversion result.
- fifo_rd  in  1  pop request.
- fifo_dout  out  16  {1'b0, ch[2:0], data[11:0]}; head entry, valid while !fifo_empty.
- fifo_empty  out  1  FIFO is empty.
- fifo_full  out  1  FIFO is full.
- fifo_level  out  ADDR_W+1  current occupancy.
- overflow  out  1  sticky: a sample was dropped.
- timeout_err  out  1  sticky: a conversion timed out.
- err_clr  in  1  synchronous clear of overflow and timeout_err.
- scan_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FSM goes to IDLE.
  - measure_start=0, measure_ch=0, scan_busy=0.
  - FIFO pointers and level are 0, so fifo_empty=1, fifo_full=0, fifo_dout=0.
  - overflow=0, timeout_err=0, last-channel register=7 (so the first scan starts at channel 0).
  - A reset mid-conversion abandons that conversion; the result is never written.
- FSM states: IDLE, SELECT, START, WAIT, CAPTURE, GAP.
- IDLE:
  - Go to SELECT when scan_enable=1 and ch_mask!=0.
- SELECT (1 cycle):
  - If scan_enable=0 or ch_mask=0, go to IDLE.
  - Otherwise choose the first set bit of ch_mask searching last+1, last+2, ... with modulo-8 wrap.
  - Register that channel into measure_ch and into last, then go to START.
  - ch_mask is sampled only in SELECT; mask changes at other times take effect at the next SELECT.
- START:
  - measure_start=1 for exactly START_CYCLES cycles, then go to WAIT.
  - measure_ch is held constant from SELECT through CAPTURE.
- WAIT:
  - measure_start=0.
  - The done signal is ignored during the first 2 WAIT cycles, which covers the conversion block's done-clear latency.
  - After that, measure_done=1 goes to CAPTURE.
  - If the WAIT cycle count reaches TIMEOUT_CYCLES, set timeout_err and go to GAP with no write.
- CAPTURE (1 cycle):
  - Write {1'b0, measure_ch, measure_dataread} to the FIFO, then go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to SELECT.
  - With GAP_CYCLES=0, go straight to SELECT.
- If scan_enable drops mid-scan, the in-flight conversion completes and is captured; the FSM returns to IDLE at the next SELECT.
- FIFO behaviour:
  - Show-ahead: fifo_dout = mem[rd_ptr] combinationally; it is 0 when empty after reset and otherwise the stale head.
  - A read with fifo_rd=1 while empty is ignored; pointers and level are unchanged.
  - A write while full is accepted only if a read occurs in the same cycle (level stays at FIFO_DEPTH). Otherwise the new sample is dropped, overflow is set, and the FIFO contents are unchanged.
  - Simultaneous read and write when not full or empty: both occur and the level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is registered and updates the cycle after the operation; fifo_full = (level==FIFO_DEPTH) and fifo_empty = (level==0).
- Error flags:
  - overflow and timeout_err are sticky until err_clr or reset.
  - If err_clr coincides with a new error event, the set wins.

Test Plan:
- ch_mask=8'hFF with an ADC model returning data = 12'h100+ch -> FIFO entries in order 16'h0100, 16'h1101 ... 16'h7107, then 16'h0100 (wrap); every measure_start pulse is exactly 2 cycles wide.
- ch_mask=8'b1000_0100 -> channel sequence 2, 7, 2, 7; no other channel is ever driven on measure_ch.
- No reads performed, 17 conversions -> fifo_full=1, fifo_level=16, overflow=1, head entry is still the first sample; err_clr pulse -> overflow=0.
- FIFO full with fifo_rd=1 held in the CAPTURE cycle -> level stays 16, overflow stays 0, newest sample is stored; fifo_rd while empty -> fifo_level stays 0.
- ADC model never asserts done -> timeout_err=1 after 200 WAIT cycles, no FIFO write, scan advances to the next channel.
- Assert reset_n=0 in the middle of WAIT -> measure_start=0, fifo_level=0, scan_busy=0 immediately; after release with scan_enable=1 the scan restarts at channel 0.
